// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// A zero divisor completes in a single cycle with an all-ones quotient and div_by_zero set.
module seq_restoring_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  q_sh;
  logic [VW-1:0]  d_r;
  logic [VW-1:0]  p;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last_step;
  logic [VW:0]    t;
  logic           ge;
  logic [VW-1:0]  p_step;
  logic [DW-1:0]  q_step;

  assign accept    = start && (state != S_RUN);
  assign last_step = (cnt == CW'(1));

  // Partial remainder is kept VW bits wide: p < d_r between steps, so its
  // would-be top bit is always zero and only matters inside the trial value t.
  assign t      = {p, q_sh[DW-1]};
  assign ge     = (t >= {1'b0, d_r});
  assign p_step = ge ? VW'(t - {1'b0, d_r}) : t[VW-1:0];
  assign q_step = {q_sh[DW-2:0], ge};

  // NOTE: every variable in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) state_nx = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: if (last_step) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sh        <= '0;
      d_r         <= '0;
      p           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        q_sh <= dividend;
        d_r  <= divisor;
        p    <= '0;
        cnt  <= CW'(DW);
      end else begin
        quotient    <= '1;
        remainder   <= dividend[VW-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == S_RUN) begin
      q_sh <= q_step;
      p    <= p_step;
      cnt  <= cnt - CW'(1);
      if (last_step) begin
        quotient    <= q_step;
        remainder   <= p_step;
        div_by_zero <= 1'b0;
      end
    end
  end

  assign ready = (state != S_RUN);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (DW=16, VW=8).
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_seq_restoring_divider;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete divide: pulse start, wait for done, check timing and results.
  task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz);
    int n;
    int busy_n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    check({tag, " latency"}, n, edbz ? 0 : DW);
    check({tag, " busy_cycles"}, busy_n, edbz ? 0 : DW);
    check({tag, " done"}, done, 1);
    check({tag, " ready_in_done"}, ready, 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    if (!edbz) begin
      check({tag, " identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, " rem_lt_div"}, remainder < b, 1);
    end
    tick();
    check({tag, " done_pulse_end"}, done, 0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [DW-1:0] got_q;
    logic [VW-1:0] got_r;
    logic [DW-1:0] a;
    logic [VW-1:0] b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_div("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    run_div("65535/255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
    run_div("5/9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
    run_div("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1);

    // start pulsed mid-divide must be ignored; previous results hold until completion
    dividend = 16'd100;
    divisor  = 8'd10;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dividend = 16'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    check("ignore ready_low", ready, 0);
    tick();
    start = 1'b0;
    check("ignore hold_quotient", quotient, 16'hFFFF);
    check("ignore hold_dbz", div_by_zero, 1);
    pulses = 0;
    got_q  = '0;
    got_r  = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        got_q = quotient;
        got_r = remainder;
      end
      tick();
    end
    check("ignore pulses", pulses, 1);
    check("ignore quotient", got_q, 16'd10);
    check("ignore remainder", got_r, 8'd0);
    check("ignore dbz_cleared", div_by_zero, 0);

    // start held high through DONE: back-to-back accept
    dividend = 16'd81;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("b2b first_done", done, 1);
    check("b2b first_quotient", quotient, 16'd9);
    check("b2b first_remainder", remainder, 8'd0);
    dividend = 16'd200;
    divisor  = 8'd13;
    tick();
    n = 1;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("b2b spacing", n, DW + 1);
    check("b2b second_quotient", quotient, 16'd15);
    check("b2b second_remainder", remainder, 8'd5);
    tick();
    check("b2b done_end", done, 0);

    // asynchronous reset at RUN cycle 8 aborts the divide
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort ready", ready, 1);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    tick();
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort no_done", pulses, 0);
    run_div("300/17", 16'd300, 8'd17, 16'd17, 8'd11, 1'b0);

    // boundary vectors
    run_div("0/1", 16'd0, 8'd1, 16'd0, 8'd0, 1'b0);
    run_div("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
    run_div("255/255", 16'd255, 8'd255, 16'd1, 8'd0, 1'b0);
    run_div("254/255", 16'd254, 8'd255, 16'd0, 8'd254, 1'b0);
    run_div("65535/0", 16'd65535, 8'd0, 16'hFFFF, 8'hFF, 1'b1);

    // short sweep against the arithmetic reference
    for (int i = 0; i < 120; i++) begin
      a = DW'($urandom);
      b = VW'($urandom_range(1, 255));
      run_div("sweep", a, b, a / DW'(b), VW'(a % DW'(b)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
